// File: rtl/pe_sched_pkg.sv
// Shared types and sizing helpers for the PE tile scheduler.
// Imported by the scheduler, its drain unit and the bus interface.
package pe_sched_pkg;
  localparam int DEF_N = 786;
  localparam int DEF_DW = 16;
  localparam int DEF_PE_NUM = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_PE,
    DRAIN,
    DONE
  } state_t;

  typedef logic signed [2*DEF_DW-1:0] res_t;

  function automatic int calc_rw(int n, int p);
    return $clog2(n + p);
  endfunction

  function automatic int calc_tiles(int n, int p);
    return (n + p - 1) / p;
  endfunction
endpackage

// File: rtl/pe_tile_scheduler_if.sv
// Control, tile-offer, PE-result and y-write bundle of the scheduler.
// master = scheduler side, slave = array / memory / control side.
interface pe_tile_scheduler_if
  import pe_sched_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int DW = DEF_DW,
  parameter int PE_NUM = DEF_PE_NUM,
  parameter int RW = calc_rw(N, PE_NUM)
);
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic tile_valid;
  logic tile_ready;
  logic [RW-1:0] tile_row;
  logic [PE_NUM-1:0] tile_mask;
  logic [PE_NUM-1:0] pe_done;
  logic [PE_NUM*2*DW-1:0] pe_y;
  logic y_we;
  logic [RW-1:0] y_addr;
  logic [2*DW-1:0] y_wdata;
  logic y_wr_ready;

  modport master (
    input start, abort, tile_ready,
    input pe_done, pe_y, y_wr_ready,
    output busy, done, tile_valid,
    output tile_row, tile_mask,
    output y_we, y_addr, y_wdata
  );

  modport slave (
    output start, abort, tile_ready,
    output pe_done, pe_y, y_wr_ready,
    input busy, done, tile_valid,
    input tile_row, tile_mask,
    input y_we, y_addr, y_wdata
  );
endinterface

// File: rtl/pe_result_drain.sv
// Captures one tile of PE results and serializes the live entries
// to the y write port under y_wr_ready backpressure.
module pe_result_drain
  import pe_sched_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int PE_NUM = DEF_PE_NUM,
  parameter int RW = calc_rw(DEF_N, DEF_PE_NUM)
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  input  logic load,
  input  logic [RW-1:0] row,
  input  logic [PE_NUM-1:0] mask,
  input  logic [PE_NUM*2*DW-1:0] pe_y,
  input  logic wr_ready,
  output logic we,
  output logic [RW-1:0] addr,
  output logic [2*DW-1:0] wdata,
  output logic last
);
  localparam int KW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  typedef logic signed [2*DW-1:0] word_t;

  word_t buf_q [PE_NUM];
  logic [PE_NUM-1:0] rem;
  logic [KW-1:0] k;
  logic [KW-1:0] kn;
  logic fire;

  // live entries are contiguous from PE 0, so rem[0] says "one more"
  assign kn = k + 1'b1;
  assign fire = we && wr_ready;
  assign last = fire && !rem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PE_NUM; i++) buf_q[i] <= '0;
      rem <= '0;
      k <= '0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
    end else if (abort) begin
      rem <= '0;
      k <= '0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
    end else if (load) begin
      for (int i = 0; i < PE_NUM; i++)
        buf_q[i] <= mask[i] ? pe_y[i*2*DW +: 2*DW] : '0;
      rem <= mask >> 1;
      k <= '0;
      we <= 1'b1;
      addr <= row;
      wdata <= pe_y[2*DW-1:0];
    end else if (fire) begin
      rem <= rem >> 1;
      if (rem[0]) begin
        k <= kn;
        addr <= row + RW'(kn);
        wdata <= buf_q[kn];
      end else begin
        k <= '0;
        we <= 1'b0;
        addr <= '0;
        wdata <= '0;
      end
    end
  end
endmodule

// File: rtl/pe_tile_scheduler.sv
// Sequences row tiles of an N x N mat-vec onto a PE_NUM-wide array,
// waits for the live PEs, then drains results to the y memory.
module pe_tile_scheduler
  import pe_sched_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int DW = DEF_DW,
  parameter int PE_NUM = DEF_PE_NUM,
  parameter int RW = calc_rw(N, PE_NUM)
) (
  input logic clk,
  input logic rst,
  pe_tile_scheduler_if.master bus
);
  state_t state;
  logic busy;
  logic done;
  logic tile_valid;
  logic [RW-1:0] tile_row;
  logic [PE_NUM-1:0] tile_mask;
  logic [RW-1:0] next_row;
  logic all_done;
  logic load;
  logic drain_last;
  logic y_we;
  logic [RW-1:0] y_addr;
  logic [2*DW-1:0] y_wdata;

  function automatic logic [PE_NUM-1:0] row_mask(logic [RW-1:0] r);
    logic [PE_NUM-1:0] m;
    for (int i = 0; i < PE_NUM; i++)
      m[i] = (r + RW'(i)) < RW'(N);
    return m;
  endfunction

  assign all_done = &(bus.pe_done | ~tile_mask);
  assign load = (state == WAIT_PE) && all_done && !bus.abort;
  assign next_row = tile_row + RW'(PE_NUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      tile_valid <= 1'b0;
      tile_row <= '0;
      tile_mask <= '0;
    end else if (bus.abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      tile_valid <= 1'b0;
      tile_row <= '0;
      tile_mask <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= ISSUE;
            busy <= 1'b1;
            tile_valid <= 1'b1;
            tile_row <= '0;
            tile_mask <= row_mask('0);
          end
        end
        ISSUE: begin
          if (bus.tile_ready) begin
            state <= WAIT_PE;
            tile_valid <= 1'b0;
          end
        end
        WAIT_PE: begin
          if (all_done) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_last) begin
            if (next_row >= RW'(N)) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= ISSUE;
              tile_valid <= 1'b1;
              tile_row <= next_row;
              tile_mask <= row_mask(next_row);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
          tile_row <= '0;
          tile_mask <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pe_result_drain #(
    .DW(DW),
    .PE_NUM(PE_NUM),
    .RW(RW)
  ) u_drain (
    .clk(clk),
    .rst(rst),
    .abort(bus.abort),
    .load(load),
    .row(tile_row),
    .mask(tile_mask),
    .pe_y(bus.pe_y),
    .wr_ready(bus.y_wr_ready),
    .we(y_we),
    .addr(y_addr),
    .wdata(y_wdata),
    .last(drain_last)
  );

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.tile_valid = tile_valid;
  assign bus.tile_row = tile_row;
  assign bus.tile_mask = tile_mask;
  assign bus.y_we = y_we;
  assign bus.y_addr = y_addr;
  assign bus.y_wdata = y_wdata;
endmodule

// File: doc/pe_tile_scheduler.md
Name: pe_tile_scheduler

Overview:
- Sequences row tiles of an N×N matrix-vector product onto a PE_NUM-wide PE array.
- Issues one tile per handshake, waits on per-PE done flags, then serially writes the tile's results to a y memory port with backpressure.
- Sits between the top-level start/done control and the PE array / y buffer.
- Handles N not divisible by PE_NUM by masking the tail tile.

Parameters:
- N, 786, matrix dimension (rows = cols).
- DW, 16, operand width; results are 2*DW signed.
- PE_NUM, 8, PEs per tile.
- RW, $clog2(N+PE_NUM), row/address index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job completion.
- tile_valid  out  1  tile offer to PE array.
- tile_ready  in  1  PE array accepts tile.
- tile_row  out  RW  base row of offered tile.
- tile_mask  out  PE_NUM  bit k set iff tile_row+k < N.
- pe_done  in  PE_NUM  per-PE done flags.
- pe_y  in  PE_NUM*2*DW  packed PE results, PE k at bits [k*2DW +: 2DW].
- y_we  out  1  write request to y memory.
- y_addr  out  RW  y row address.
- y_wdata  out  2*DW  result word.
- y_wr_ready  in  1  y memory accepts write.

Behaviour:
- Reset values: all outputs 0; state IDLE; row counter 0; drain index 0; result buffer 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_PE, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 -> row=0, ISSUE.
  - tile_valid asserts the next cycle, i.e. 1 cycle after start.
- ISSUE:
  - tile_valid=1.
  - tile_row and tile_mask stay stable until tile_valid&&tile_ready.
  - On that handshake -> WAIT_PE; tile_valid drops the next cycle.
- WAIT_PE:
  - pe_done is sampled only in this state.
  - Flags present during the handshake cycle are ignored.
  - Exit condition: &(pe_done | ~tile_mask) = 1.
  - On exit, capture pe_y for the masked PEs into the result buffer, set k=0, go to DRAIN.
  - No timeout.
- DRAIN:
  - y_we=1, y_addr=tile_row+k, y_wdata=buf[k].
  - k advances only on y_we&&y_wr_ready; addr/data hold while y_wr_ready=0.
  - Only masked entries are written, in ascending k.
  - After the last masked write:
    - if tile_row+PE_NUM >= N -> DONE;
    - else tile_row += PE_NUM -> ISSUE.
- DONE: done=1 for one cycle -> IDLE.
- Tile count = ceil(N/PE_NUM). N=786, PE_NUM=8: 99 tiles; last tile_row=784, mask=8'b0000_0011.
- Minimum cycles per full tile = 1 (issue) + PE latency + PE_NUM (drain).
- abort:
  - Next state is IDLE and all outputs drop to 0 next cycle.
  - No done pulse; partial y writes already accepted stand.
  - abort has priority over start and over any handshake completing in the same cycle.
- start while busy: ignored.
- rst mid-job: immediate return to reset values; no done pulse.
- Arithmetic: results are passed through unmodified, no truncation or saturation. Row arithmetic is in RW bits so tile_row+PE_NUM cannot overflow.

Decomposition:
- Package pe_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT_PE, DRAIN, DONE);
  - localparam functions for RW and tile count;
  - result word typedef (signed [2*DW-1:0]).
- One sub-module, pe_result_drain:
  - PE_NUM-entry result buffer, load on capture;
  - mask-aware serializer with the y_we/y_wr_ready handshake;
  - drain_last output to the scheduler FSM.

Test Plan:
- N=10, PE_NUM=4, immediate tile_ready, pe_done=4'hF 3 cycles after accept, y_wr_ready=1:
  - tiles at rows 0,4,8 with masks 1111,1111,0011;
  - 10 y writes, addr 0..9, data equal to the driven pe_y;
  - done pulses exactly once;
  - busy falls with done.
- Tail mask: N=10, last tile pe_done=4'b0011 only (PEs 2,3 never done) -> exits WAIT_PE, writes addr 8,9 only.
- Backpressure:
  - tile_ready low for 5 cycles -> tile_row/tile_mask stable throughout;
  - y_wr_ready toggling 1,0,0,1 -> no write lost or duplicated, y_addr/y_wdata held during stalls.
- Abort in DRAIN after 2 accepted writes -> outputs 0 next cycle, no done; a new start then restarts at tile_row=0.
- start pulsed during WAIT_PE, and start+abort together in IDLE -> both ignored, no state change beyond abort.
- Async rst asserted mid-WAIT_PE -> all outputs 0 immediately; after release, start runs a full 99-tile job with default N=786, PE_NUM=8, last mask 8'h03, 786 writes total.
